// File: rtl/seq_mult_iter.sv
// Iterative shift-and-add multiplier: one partial product per clock, signed or
// unsigned operands selected per operation, start/busy/done handshake.
module seq_mult_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     ain,
    input  logic [WIDTH-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prodout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1'b1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2*WIDTH)'(1'b1);
    localparam logic [CNT_W-1:0]   ONE_C    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [2*WIDTH:0]     acc_r;      // {upper half with carry, multiplier bits}
    logic                 neg_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH:0]     acc_next_s;
    logic [2*WIDTH-1:0]   prod_s;

    // |v| for two's complement operands; the most negative value maps onto itself
    // and is correct when read back as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
        if (sm && v[WIDTH-1]) begin
            magnitude = ~v + ONE_W;
        end else begin
            magnitude = v;
        end
    endfunction

    // One shift-and-add step plus the sign-corrected product of the final step.
    always_comb begin
        addend_s   = {WIDTH{1'b0}};
        sum_s      = {(WIDTH+1){1'b0}};
        acc_next_s = {(2*WIDTH+1){1'b0}};
        prod_s     = {(2*WIDTH){1'b0}};
        if (acc_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s      = acc_r[2*WIDTH:WIDTH] + {1'b0, addend_s};
        acc_next_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
        if (neg_r) begin
            prod_s = ~acc_next_s[2*WIDTH-1:0] + ONE_P;
        end else begin
            prod_s = acc_next_s[2*WIDTH-1:0];
        end
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            mcand_r <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH+1){1'b0}};
            neg_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            prodout <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_r <= magnitude(ain, signed_mode);
                        acc_r   <= {{(WIDTH+1){1'b0}}, magnitude(bin, signed_mode)};
                        neg_r   <= signed_mode & (ain[WIDTH-1] ^ bin[WIDTH-1]);
                        cnt_r   <= {CNT_W{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + ONE_C;
                    if (cnt_r == LAST_CNT) begin
                        prodout <= prod_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_iter.sv
// Self-checking bench for seq_mult_iter at WIDTH=8 and WIDTH=4 against an
// arithmetic reference model, with literal expectations for the directed cases.
module tb_seq_mult_iter;

    logic        clk, rst;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    int checks = 0;
    int errors = 0;

    seq_mult_iter #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .ain(a8), .bin(b8), .busy(busy8), .done(done8), .prodout(p8)
    );

    seq_mult_iter #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .ain(a4), .bin(b4), .busy(busy4), .done(done4), .prodout(p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain integer product, truncated to 2*w bits.
    function automatic longint ref_mul(longint a, longint b, bit sm, int w);
        longint x;
        longint y;
        x = a;
        y = b;
        if (sm && a[w-1]) x = a - (longint'(1) << w);
        if (sm && b[w-1]) y = b - (longint'(1) << w);
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request yields its product WIDTH edges later.
    longint m_prod8 = 0, pend8 = 0, m_prod4 = 0, pend4 = 0;
    bit     m_busy8 = 0, m_done8 = 0, m_busy4 = 0, m_done4 = 0;
    int     m_left8 = 0, m_left4 = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_prod8 = 0; m_busy8 = 0; m_done8 = 0; m_left8 = 0;
            m_prod4 = 0; m_busy4 = 0; m_done4 = 0; m_left4 = 0;
        end else begin
            if (m_left8 > 0) begin
                m_left8--;
                if (m_left8 == 0) begin
                    m_busy8 = 0; m_done8 = 1; m_prod8 = pend8;
                end
            end else begin
                m_done8 = 0;
                if (start8) begin
                    pend8 = ref_mul(longint'(a8), longint'(b8), sm8, 8);
                    m_left8 = 8; m_busy8 = 1;
                end
            end
            if (m_left4 > 0) begin
                m_left4--;
                if (m_left4 == 0) begin
                    m_busy4 = 0; m_done4 = 1; m_prod4 = pend4;
                end
            end else begin
                m_done4 = 0;
                if (start4) begin
                    pend4 = ref_mul(longint'(a4), longint'(b4), sm4, 4);
                    m_left4 = 4; m_busy4 = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy8", 64'(busy8), 64'(m_busy8));
        check("done8", 64'(done8), 64'(m_done8));
        check("prod8", 64'(p8), m_prod8);
        check("busy4", 64'(busy4), 64'(m_busy4));
        check("done4", 64'(done4), 64'(m_done4));
        check("prod4", 64'(p4), m_prod4);
    end

    task automatic issue(input bit w4, input logic [7:0] a, input logic [7:0] b, input bit sm);
        if (w4) begin
            a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; start4 = 1'b1;
        end else begin
            a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        end
    endtask

    task automatic start_op(input bit w4, input logic [7:0] a, input logic [7:0] b, input bit sm);
        @(negedge clk);
        issue(w4, a, b, sm);
    endtask

    // Counts negedges from the request until done; keep=1 holds start high with
    // fresh random operands the whole time.
    task automatic wait_done(input bit w4, input bit keep, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (!keep) begin
                start8 = 1'b0; start4 = 1'b0;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
                a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
            end
            if ((w4 ? done4 : done8) === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done timeout w4=%0d after %0d cycles", w4, n);
    endtask

    logic [7:0]  dir_a   [6] = '{8'hFF, 8'hFD, 8'hFD, 8'h80, 8'h80, 8'h00};
    logic [7:0]  dir_b   [6] = '{8'hFF, 8'h05, 8'h05, 8'h80, 8'h7F, 8'h80};
    bit          dir_sm  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] dir_exp [6] = '{16'hFE01, 16'hFFF1, 16'h04F1, 16'h4000, 16'hC080, 16'h0000};

    initial begin
        int n;
        int pulses;
        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start4 = 1'b0; sm4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy8), 64'(0));
        check("reset_done", 64'(done8), 64'(0));
        check("reset_prod", 64'(p8), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_op(1'b0, dir_a[i], dir_b[i], dir_sm[i]);
            wait_done(1'b0, 1'b0, n);
            check("latency8", 64'(n), 64'(9));
            check("dir_prod8", 64'(p8), 64'(dir_exp[i]));
        end

        // start held through RUN, then a back-to-back request in the DONE cycle
        start_op(1'b0, 8'h12, 8'h34, 1'b0);
        wait_done(1'b0, 1'b1, n);
        check("held_start_prod", 64'(p8), 64'(16'h03A8));
        wait_done(1'b0, 1'b0, n);
        check("b2b_latency_a", 64'(n), 64'(9));
        issue(1'b0, 8'd3, 8'd7, 1'b0);
        wait_done(1'b0, 1'b0, n);
        check("b2b_latency_b", 64'(n), 64'(9));
        check("b2b_prod", 64'(p8), 64'(16'h0015));

        // reset on the fourth RUN edge aborts the operation
        start_op(1'b0, 8'hAB, 8'hCD, 1'b0);
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy8), 64'(0));
        check("abort_done", 64'(done8), 64'(0));
        check("abort_prod", 64'(p8), 64'(0));
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'(0));
        start_op(1'b0, 8'h0F, 8'h0E, 1'b0);
        wait_done(1'b0, 1'b0, n);
        check("after_abort_prod", 64'(p8), 64'(16'h00D2));

        start_op(1'b1, 8'h0F, 8'h0F, 1'b0);
        wait_done(1'b1, 1'b0, n);
        check("latency4", 64'(n), 64'(5));
        check("w4_unsigned", 64'(p4), 64'(8'hE1));
        start_op(1'b1, 8'h08, 8'h08, 1'b1);
        wait_done(1'b1, 1'b0, n);
        check("w4_signed", 64'(p4), 64'(8'h40));

        // random traffic, including ignored requests while busy and stray resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 2) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            start4 = ($urandom_range(0, 2) == 0);
            a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
            rst = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
